// File: rtl/csc_pkg.sv
// Shared constants for the YUV->RGB colour-space converter: fraction bits,
// luma gain, per-matrix chroma coefficients and MPEG-2 matrix code decode.
package csc_pkg;

  localparam int CSC_FRAC_BITS = 15;
  localparam int CSC_CY        = 38155;

  typedef enum logic [1:0] {
    MAT_709  = 2'd0,
    MAT_170M = 2'd1,
    MAT_FCC  = 2'd2,
    MAT_240M = 2'd3
  } csc_matrix_e;

  typedef struct packed {
    int crv;
    int cbu;
    int cgu;
    int cgv;
  } csc_coef_t;

  function automatic csc_matrix_e csc_decode_matrix(input logic [7:0] code);
    case (code)
      8'd2, 8'd3, 8'd5, 8'd6: return MAT_170M;
      8'd4:                   return MAT_FCC;
      8'd7:                   return MAT_240M;
      default:                return MAT_709;
    endcase
  endfunction

  function automatic csc_coef_t csc_coef(input csc_matrix_e mat);
    case (mat)
      MAT_170M: return '{crv: 52299, cbu: 66101, cgu: 12838, cgv: 26640};
      MAT_FCC:  return '{crv: 52224, cbu: 66399, cgu: 12380, cgv: 26555};
      MAT_240M: return '{crv: 58790, cbu: 68115, cgu: 8454,  cgv: 17780};
      default:  return '{crv: 58752, cbu: 69227, cgu: 6977,  cgv: 17452};
    endcase
  endfunction

endpackage

// File: rtl/csc_pipe_if.sv
// Pixel stream interface for csc_pipe: YUV input beat with sideband and
// ready/valid handshake on both sides, RGB output beat with syncs.
interface csc_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [IN_W-1:0]  y;
  logic [IN_W-1:0]  u;
  logic [IN_W-1:0]  v;
  logic             in_h_sync;
  logic             in_v_sync;
  logic             in_pixel_en;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] r;
  logic [OUT_W-1:0] g;
  logic [OUT_W-1:0] b;
  logic             out_h_sync;
  logic             out_v_sync;
  logic             out_pixel_en;
  logic             out_c_sync;

  modport slave (
    input  in_valid, in_sof, y, u, v, in_h_sync, in_v_sync, in_pixel_en, out_ready,
    output in_ready, out_valid, r, g, b, out_h_sync, out_v_sync, out_pixel_en, out_c_sync
  );

  modport master (
    output in_valid, in_sof, y, u, v, in_h_sync, in_v_sync, in_pixel_en, out_ready,
    input  in_ready, out_valid, r, g, b, out_h_sync, out_v_sync, out_pixel_en, out_c_sync
  );
endinterface

// File: rtl/csc_clip.sv
// Round-to-nearest, arithmetic shift right by SHIFT, then saturate to the
// unsigned range [0, 2^OUT_W-1].
module csc_clip #(
  parameter int SUM_W = 29,
  parameter int OUT_W = 8,
  parameter int SHIFT = 15
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [OUT_W-1:0] clipped
);

  localparam logic signed [SUM_W:0] ROUND = (SUM_W+1)'(1 << (SHIFT-1));
  localparam logic signed [SUM_W:0] MAX   = (SUM_W+1)'((1 << OUT_W) - 1);

  logic signed [SUM_W:0] rounded;

  // One guard bit so adding the rounding constant can never wrap
  always_comb begin
    rounded = ((SUM_W+1)'(sum) + ROUND) >>> SHIFT;
    if (rounded[SUM_W]) begin
      clipped = '0;
    end else if (rounded > MAX) begin
      clipped = '1;
    end else begin
      clipped = rounded[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/csc_pipe.sv
// 4-stage YUV->RGB converter (offset, multiply, sum, round/clip) with
// per-frame matrix selection. Optional passthrough enabled by CSC_BYPASS_EN.
module csc_pipe
  import csc_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] matrix_coefficients,
`ifdef CSC_BYPASS_EN
  input  logic       bypass,
`endif
  csc_pipe_if.slave  bus
);

  localparam int PW    = IN_W + 1 + COEF_W;
  localparam int SW    = PW + 2;
  localparam int SHIFT = CSC_FRAC_BITS + IN_W - OUT_W;
  localparam logic signed [IN_W:0] Y_OFF = (IN_W+1)'(16 << (IN_W-8));
  localparam logic signed [IN_W:0] C_OFF = (IN_W+1)'(128 << (IN_W-8));

  logic advance, accept;
  csc_matrix_e mat_q, mat_d, sel_mat;
  csc_coef_t coef;
  logic signed [COEF_W-1:0] cy_c, crv_c, cbu_c, cgu_c, cgv_c;
  logic signed [IN_W:0] y_off, c_off;

  logic s1_valid_q, s1_valid_d;
  logic signed [IN_W:0] s1_y_q, s1_y_d, s1_u_q, s1_u_d, s1_v_q, s1_v_d;
  csc_matrix_e s1_mat_q, s1_mat_d;
  logic [2:0] s1_sb_q, s1_sb_d;

  logic s2_valid_q, s2_valid_d;
  logic signed [PW-1:0] s2_py_q, s2_py_d, s2_pcrv_q, s2_pcrv_d, s2_pcbu_q, s2_pcbu_d;
  logic signed [PW-1:0] s2_pcgu_q, s2_pcgu_d, s2_pcgv_q, s2_pcgv_d;
  logic [2:0] s2_sb_q, s2_sb_d;

  logic s3_valid_q, s3_valid_d;
  logic signed [SW-1:0] s3_r_q, s3_r_d, s3_g_q, s3_g_d, s3_b_q, s3_b_d;
  logic [2:0] s3_sb_q, s3_sb_d;

  logic out_valid_q, out_valid_d;
  logic [OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d, r_clip, g_clip, b_clip;
  logic [2:0] out_sb_q, out_sb_d;
  logic c_sync_q, c_sync_d;

`ifdef CSC_BYPASS_EN
  logic byp_q, byp_d, sel_byp, s1_byp_q, s1_byp_d, s2_byp_q, s2_byp_d;
`endif

  // A sof beat picks its matrix combinationally so the new set applies to
  // that beat itself; beats already in flight carry their own stage-1 copy.
  always_comb begin
    advance = clk_en & (~out_valid_q | bus.out_ready);
    accept  = advance & bus.in_valid;
    sel_mat = (accept && bus.in_sof) ? csc_decode_matrix(matrix_coefficients) : mat_q;
    y_off   = Y_OFF;
    c_off   = C_OFF;

    coef  = csc_coef(s1_mat_q);
    cy_c  = COEF_W'(CSC_CY);
    crv_c = COEF_W'(coef.crv);
    cbu_c = COEF_W'(coef.cbu);
    cgu_c = COEF_W'(coef.cgu);
    cgv_c = COEF_W'(coef.cgv);

    mat_d = mat_q;
    s1_valid_d = s1_valid_q; s1_y_d = s1_y_q; s1_u_d = s1_u_q; s1_v_d = s1_v_q;
    s1_mat_d = s1_mat_q; s1_sb_d = s1_sb_q;
    s2_valid_d = s2_valid_q; s2_py_d = s2_py_q; s2_pcrv_d = s2_pcrv_q;
    s2_pcbu_d = s2_pcbu_q; s2_pcgu_d = s2_pcgu_q; s2_pcgv_d = s2_pcgv_q; s2_sb_d = s2_sb_q;
    s3_valid_d = s3_valid_q; s3_r_d = s3_r_q; s3_g_d = s3_g_q; s3_b_d = s3_b_q;
    s3_sb_d = s3_sb_q;
    out_valid_d = out_valid_q; r_d = r_q; g_d = g_q; b_d = b_q;
    out_sb_d = out_sb_q; c_sync_d = c_sync_q;

`ifdef CSC_BYPASS_EN
    // Passthrough routes y/u/v unscaled into r/g/b via unity gains
    sel_byp  = (accept && bus.in_sof) ? bypass : byp_q;
    byp_d    = byp_q;
    s1_byp_d = s1_byp_q;
    s2_byp_d = s2_byp_q;
    if (sel_byp) begin
      y_off = '0;
      c_off = '0;
    end
    if (s1_byp_q) begin
      cy_c  = COEF_W'(1 << CSC_FRAC_BITS);
      cgu_c = COEF_W'(1 << CSC_FRAC_BITS);
      cgv_c = COEF_W'(1 << CSC_FRAC_BITS);
    end
`endif

    if (advance) begin
      mat_d      = sel_mat;
      s1_valid_d = bus.in_valid;
      s1_y_d     = $signed({1'b0, bus.y}) - y_off;
      s1_u_d     = $signed({1'b0, bus.u}) - c_off;
      s1_v_d     = $signed({1'b0, bus.v}) - c_off;
      s1_mat_d   = sel_mat;
      s1_sb_d    = {bus.in_h_sync, bus.in_v_sync, bus.in_pixel_en};

      s2_valid_d = s1_valid_q;
      s2_py_d    = PW'(s1_y_q) * PW'(cy_c);
      s2_pcrv_d  = PW'(s1_v_q) * PW'(crv_c);
      s2_pcbu_d  = PW'(s1_u_q) * PW'(cbu_c);
      s2_pcgu_d  = PW'(s1_u_q) * PW'(cgu_c);
      s2_pcgv_d  = PW'(s1_v_q) * PW'(cgv_c);
      s2_sb_d    = s1_sb_q;

      s3_valid_d = s2_valid_q;
      s3_r_d     = SW'(s2_py_q) + SW'(s2_pcrv_q);
      s3_g_d     = SW'(s2_py_q) - SW'(s2_pcgu_q) - SW'(s2_pcgv_q);
      s3_b_d     = SW'(s2_py_q) + SW'(s2_pcbu_q);
      s3_sb_d    = s2_sb_q;

      out_valid_d = s3_valid_q;
      r_d         = r_clip;
      g_d         = g_clip;
      b_d         = b_clip;
      out_sb_d    = s3_sb_q;
      c_sync_d    = ~(s3_sb_q[2] ^ s3_sb_q[1]);

`ifdef CSC_BYPASS_EN
      byp_d    = sel_byp;
      s1_byp_d = sel_byp;
      s2_byp_d = s1_byp_q;
      if (s2_byp_q) begin
        s3_r_d = SW'(s2_py_q);
        s3_g_d = SW'(s2_pcgu_q);
        s3_b_d = SW'(s2_pcgv_q);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mat_q <= MAT_709;
      s1_valid_q <= 1'b0; s1_y_q <= '0; s1_u_q <= '0; s1_v_q <= '0;
      s1_mat_q <= MAT_709; s1_sb_q <= '0;
      s2_valid_q <= 1'b0; s2_py_q <= '0; s2_pcrv_q <= '0; s2_pcbu_q <= '0;
      s2_pcgu_q <= '0; s2_pcgv_q <= '0; s2_sb_q <= '0;
      s3_valid_q <= 1'b0; s3_r_q <= '0; s3_g_q <= '0; s3_b_q <= '0; s3_sb_q <= '0;
      out_valid_q <= 1'b0; r_q <= '0; g_q <= '0; b_q <= '0;
      out_sb_q <= '0; c_sync_q <= 1'b0;
`ifdef CSC_BYPASS_EN
      byp_q <= 1'b0; s1_byp_q <= 1'b0; s2_byp_q <= 1'b0;
`endif
    end else begin
      mat_q <= mat_d;
      s1_valid_q <= s1_valid_d; s1_y_q <= s1_y_d; s1_u_q <= s1_u_d; s1_v_q <= s1_v_d;
      s1_mat_q <= s1_mat_d; s1_sb_q <= s1_sb_d;
      s2_valid_q <= s2_valid_d; s2_py_q <= s2_py_d; s2_pcrv_q <= s2_pcrv_d;
      s2_pcbu_q <= s2_pcbu_d; s2_pcgu_q <= s2_pcgu_d; s2_pcgv_q <= s2_pcgv_d;
      s2_sb_q <= s2_sb_d;
      s3_valid_q <= s3_valid_d; s3_r_q <= s3_r_d; s3_g_q <= s3_g_d; s3_b_q <= s3_b_d;
      s3_sb_q <= s3_sb_d;
      out_valid_q <= out_valid_d; r_q <= r_d; g_q <= g_d; b_q <= b_d;
      out_sb_q <= out_sb_d; c_sync_q <= c_sync_d;
`ifdef CSC_BYPASS_EN
      byp_q <= byp_d; s1_byp_q <= s1_byp_d; s2_byp_q <= s2_byp_d;
`endif
    end
  end

  csc_clip #(.SUM_W(SW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_clip_r (.sum(s3_r_q), .clipped(r_clip));
  csc_clip #(.SUM_W(SW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_clip_g (.sum(s3_g_q), .clipped(g_clip));
  csc_clip #(.SUM_W(SW), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_clip_b (.sum(s3_b_q), .clipped(b_clip));

  assign bus.in_ready     = advance;
  assign bus.out_valid    = out_valid_q;
  assign bus.r            = r_q;
  assign bus.g            = g_q;
  assign bus.b            = b_q;
  assign bus.out_h_sync   = out_sb_q[2];
  assign bus.out_v_sync   = out_sb_q[1];
  assign bus.out_pixel_en = out_sb_q[0];
  assign bus.out_c_sync   = c_sync_q;

endmodule

// File: tb/tb_csc_pipe.sv
// Self-checking bench for csc_pipe: directed and random beats against an
// arithmetic reference model with a 4-slot pipeline occupancy model.
module tb_csc_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  logic [7:0] matrix_coefficients = '0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [3:0] m_v;
  int   m_r[4], m_g[4], m_b[4];
  logic m_h[4], m_vs[4], m_pe[4];
  int   m_mat;
  int   m_out, dut_out;

  always #5 clk = ~clk;

  csc_pipe_if #(.IN_W(8),  .OUT_W(8))  bus ();
  csc_pipe_if #(.IN_W(10), .OUT_W(10)) bus10 ();

  csc_pipe #(.IN_W(8), .OUT_W(8), .COEF_W(18)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .matrix_coefficients(matrix_coefficients), .bus(bus)
  );

  csc_pipe #(.IN_W(10), .OUT_W(10), .COEF_W(18)) dut10 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .matrix_coefficients(matrix_coefficients), .bus(bus10)
  );

  function automatic int code_to_mat(input int code);
    case (code)
      2, 3, 5, 6: return 1;
      4:          return 2;
      7:          return 3;
      default:    return 0;
    endcase
  endfunction

  // Reference: offset, matrix, round-to-nearest, saturate -- plain integers
  function automatic int ref_chan(input int ch, input int y, input int u, input int v,
                                  input int mat, input int in_w, input int out_w);
    longint crv, cbu, cgu, cgv, yo, uo, vo, s, q, lim;
    int sh;
    case (mat)
      1:       begin crv = 52299; cbu = 66101; cgu = 12838; cgv = 26640; end
      2:       begin crv = 52224; cbu = 66399; cgu = 12380; cgv = 26555; end
      3:       begin crv = 58790; cbu = 68115; cgu = 8454;  cgv = 17780; end
      default: begin crv = 58752; cbu = 69227; cgu = 6977;  cgv = 17452; end
    endcase
    yo = longint'(y) - longint'(16 << (in_w - 8));
    uo = longint'(u) - longint'(128 << (in_w - 8));
    vo = longint'(v) - longint'(128 << (in_w - 8));
    case (ch)
      0:       s = 38155 * yo + crv * vo;
      1:       s = 38155 * yo - cgu * uo - cgv * vo;
      default: s = 38155 * yo + cbu * uo;
    endcase
    sh  = 15 + in_w - out_w;
    lim = (longint'(1) << out_w) - 1;
    q   = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (q < 0)   q = 0;
    if (q > lim) q = lim;
    return int'(q);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, step model on the edge, check outputs
  task automatic apply_stimulus(input logic rst_n, input logic en, input logic iv,
                                input logic sof, input int code, input int y,
                                input int u, input int v, input logic h,
                                input logic vs, input logic pe, input logic ordy);
    logic adv, exp_c;
    rst = rst_n;
    clk_en = en;
    matrix_coefficients = 8'(code);
    bus.in_valid = iv;
    bus.in_sof = sof;
    bus.y = 8'(y);
    bus.u = 8'(u);
    bus.v = 8'(v);
    bus.in_h_sync = h;
    bus.in_v_sync = vs;
    bus.in_pixel_en = pe;
    bus.out_ready = ordy;
    #1;
    adv = en & (~m_v[3] | ordy);
    check_output("in_ready", bus.in_ready, adv);
    if (rst_n && en && bus.out_valid && bus.out_ready) dut_out++;
    @(posedge clk);
    if (!rst_n) begin
      m_v = '0;
      m_mat = 0;
    end else if (adv) begin
      if (m_v[3] && ordy) m_out++;
      if (iv && sof) m_mat = code_to_mat(code);
      for (int k = 3; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_r[k] = m_r[k-1]; m_g[k] = m_g[k-1]; m_b[k] = m_b[k-1];
        m_h[k] = m_h[k-1]; m_vs[k] = m_vs[k-1]; m_pe[k] = m_pe[k-1];
      end
      m_v[0] = iv;
      m_r[0] = ref_chan(0, y, u, v, m_mat, 8, 8);
      m_g[0] = ref_chan(1, y, u, v, m_mat, 8, 8);
      m_b[0] = ref_chan(2, y, u, v, m_mat, 8, 8);
      m_h[0] = h; m_vs[0] = vs; m_pe[0] = pe;
    end
    #1;
    check_output("out_valid", bus.out_valid, m_v[3]);
    if (m_v[3]) begin
      exp_c = ~(m_h[3] ^ m_vs[3]);
      check_output("r", bus.r, m_r[3]);
      check_output("g", bus.g, m_g[3]);
      check_output("b", bus.b, m_b[3]);
      check_output("h_sync", bus.out_h_sync, m_h[3]);
      check_output("v_sync", bus.out_v_sync, m_vs[3]);
      check_output("pixel_en", bus.out_pixel_en, m_pe[3]);
      check_output("c_sync", bus.out_c_sync, exp_c);
    end
  endtask

  task automatic beat(input logic sof, input int code, input int y, input int u, input int v);
    apply_stimulus(1'b1, 1'b1, 1'b1, sof, code, y, u, v,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  task automatic beat10(input int y, input int u, input int v);
    int lat;
    logic seen;
    bus10.in_valid = 1'b1;
    bus10.in_sof = 1'b1;
    bus10.y = 10'(y);
    bus10.u = 10'(u);
    bus10.v = 10'(v);
    matrix_coefficients = 8'd1;
    @(posedge clk);
    #1;
    bus10.in_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus10.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check_output("w10_seen", seen, 1'b1);
    check_output("w10_latency", lat, 4);
    check_output("w10_r", bus10.r, ref_chan(0, y, u, v, 0, 10, 10));
    check_output("w10_g", bus10.g, ref_chan(1, y, u, v, 0, 10, 10));
    check_output("w10_b", bus10.b, ref_chan(2, y, u, v, 0, 10, 10));
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_v = '0;
    m_mat = 0;
    m_out = 0;
    dut_out = 0;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
    bus.y = '0; bus.u = '0; bus.v = '0;
    bus.in_h_sync = 1'b0; bus.in_v_sync = 1'b0; bus.in_pixel_en = 1'b0;
    bus10.in_valid = 1'b0; bus10.in_sof = 1'b0; bus10.out_ready = 1'b1;
    bus10.y = '0; bus10.u = '0; bus10.v = '0;
    bus10.in_h_sync = 1'b0; bus10.in_v_sync = 1'b0; bus10.in_pixel_en = 1'b0;

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("rst_r", bus.r, 0);
    check_output("rst_g", bus.g, 0);
    check_output("rst_b", bus.b, 0);
    check_output("rst_h_sync", bus.out_h_sync, 0);
    check_output("rst_v_sync", bus.out_v_sync, 0);
    check_output("rst_pixel_en", bus.out_pixel_en, 0);
    check_output("rst_c_sync", bus.out_c_sync, 0);

    // Black, white and both clip rails with Rec.709
    beat(1'b1, 1, 16, 128, 128);
    beat(1'b0, 1, 235, 128, 128);
    beat(1'b0, 1, 255, 128, 128);
    beat(1'b0, 1, 0, 128, 128);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // 170M frame; a mid-frame code change must be ignored
    beat(1'b1, 6, 81, 90, 240);
    beat(1'b0, 1, 81, 90, 240);
    beat(1'b0, 1, 235, 128, 128);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // New frame arriving right behind beats of the previous frame
    beat(1'b1, 1, 81, 90, 240);
    beat(1'b0, 7, 81, 90, 240);
    beat(1'b1, 7, 81, 90, 240);
    beat(1'b0, 4, 200, 60, 30);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Four beats in flight, then back-pressure for 10 cycles
    for (int i = 0; i < 4; i++)
      beat(1'b0, 1, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1, $urandom_range(255), $urandom_range(255),
                     $urandom_range(255), 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    for (int i = 0; i < 400; i++)
      apply_stimulus(1'b1, 1'($urandom_range(9) != 0), 1'($urandom_range(3) != 0),
                     1'($urandom_range(15) == 0), $urandom_range(12),
                     $urandom_range(255), $urandom_range(255), $urandom_range(255),
                     1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1'($urandom_range(3) != 0));
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Reset with three beats in flight: none of them may emerge
    for (int i = 0; i < 3; i++)
      beat(1'b0, 1, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1, 100, 100, 100, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    beat(1'b0, 1, 235, 128, 128);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_output("beat_count", dut_out, m_out);

    beat10(940, 512, 512);
    beat10(64, 512, 512);
    beat10(1023, 512, 512);
    beat10(700, 300, 800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
